// File: rtl/comp_pkg.sv
// Shared types, result codes and sizing helpers for the serial magnitude comparator.
package comp_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    CMP  = 1'b1
  } state_e;

  localparam logic [1:0] RES_GT = 2'd0;
  localparam logic [1:0] RES_EQ = 2'd1;
  localparam logic [1:0] RES_LT = 2'd2;

  // Number of DIGIT-wide slices in a WIDTH-bit operand.
  function automatic int unsigned calc_ndig(input int unsigned width, input int unsigned digit);
    return width / digit;
  endfunction

  // Width needed to count 0..ndig examined digits.
  function automatic int unsigned calc_cnt_w(input int unsigned ndig);
    return $clog2(ndig + 1);
  endfunction

  // Width of the digit pointer; at least one bit even for a single digit.
  function automatic int unsigned calc_ptr_w(input int unsigned ndig);
    return (ndig > 1) ? $clog2(ndig) : 1;
  endfunction

endpackage

// File: rtl/digit_cmp.sv
// Combinational unsigned compare of one DIGIT-bit slice.
module digit_cmp #(
  parameter int unsigned DIGIT = 2
) (
  input  logic [DIGIT-1:0] i_a,
  input  logic [DIGIT-1:0] i_b,
  output logic             o_gt,
  output logic             o_eq,
  output logic             o_lt
);

  // Exactly one of the three outputs is high for any input pair.
  always_comb begin
    o_gt = (i_a > i_b);
    o_eq = (i_a == i_b);
    o_lt = (i_a < i_b);
  end

endmodule

// File: rtl/serial_mag_comparator.sv
// Multi-cycle MSB-first magnitude comparator, DIGIT bits per clock, optional early exit.
module serial_mag_comparator
  import comp_pkg::*;
#(
  parameter int unsigned WIDTH      = 8,
  parameter int unsigned DIGIT      = 2,
  parameter int unsigned EARLY_EXIT = 1
) (
  input  logic                                                i_clk,
  input  logic                                                i_rst_n,
  input  logic                                                i_start,
  input  logic                                                i_signed_mode,
  input  logic [WIDTH-1:0]                                    i_a,
  input  logic [WIDTH-1:0]                                    i_b,
  output logic                                                o_busy,
  output logic                                                o_done,
  output logic                                                o_a_greater,
  output logic                                                o_a_equal,
  output logic                                                o_a_less,
  output logic [calc_cnt_w(calc_ndig(WIDTH, DIGIT))-1:0]      o_cycles
);

  localparam int unsigned NDIG = calc_ndig(WIDTH, DIGIT);
  localparam int unsigned CW   = calc_cnt_w(NDIG);
  localparam int unsigned PW   = calc_ptr_w(NDIG);

  state_e           r_state;
  state_e           w_state_next;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [PW-1:0]    r_ptr;
  logic [CW-1:0]    r_cycles;
  logic             r_diff;     // a differing digit has already been seen (full-scan mode)
  logic             r_diff_gt;  // direction of that first difference
  logic             r_done;
  logic             r_gt;
  logic             r_eq;
  logic             r_lt;

  logic [DIGIT-1:0] w_dig_a;
  logic [DIGIT-1:0] w_dig_b;
  logic             w_gt;
  logic             w_eq;
  logic             w_lt;
  logic             w_last;
  logic             w_finish;
  logic [1:0]       w_res;
  int unsigned      w_base;

  assign w_base  = 32'(r_ptr) * DIGIT;
  assign w_dig_a = r_a[w_base +: DIGIT];
  assign w_dig_b = r_b[w_base +: DIGIT];
  assign w_last  = (r_ptr == '0);

  digit_cmp #(
    .DIGIT(DIGIT)
  ) u_digit_cmp (
    .i_a (w_dig_a),
    .i_b (w_dig_b),
    .o_gt(w_gt),
    .o_eq(w_eq),
    .o_lt(w_lt)
  );

  // Resolve the result and decide whether this CMP cycle ends the compare.
  always_comb begin
    w_finish = 1'b0;
    w_res    = RES_EQ;
    if (r_state == CMP) begin
      if (r_diff) begin
        w_res = r_diff_gt ? RES_GT : RES_LT;
      end else if (w_gt) begin
        w_res = RES_GT;
      end else if (w_lt) begin
        w_res = RES_LT;
      end
      if (w_last) begin
        w_finish = 1'b1;
      end else if ((EARLY_EXIT != 0) && !r_diff && !w_eq) begin
        w_finish = 1'b1;
      end
    end
  end

  // Next-state logic for the IDLE/CMP controller.
  always_comb begin
    w_state_next = r_state;
    unique case (r_state)
      IDLE:    if (i_start) w_state_next = CMP;
      CMP:     if (w_finish) w_state_next = IDLE;
      default: w_state_next = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Shadow operands, digit walk and result registers.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_a       <= '0;
      r_b       <= '0;
      r_ptr     <= '0;
      r_cycles  <= '0;
      r_diff    <= 1'b0;
      r_diff_gt <= 1'b0;
      r_done    <= 1'b0;
      r_gt      <= 1'b0;
      r_eq      <= 1'b0;
      r_lt      <= 1'b0;
    end else begin
      r_done <= 1'b0;
      if (r_state == IDLE) begin
        if (i_start) begin
          // Flipping the sign bit maps two's-complement order onto unsigned order.
          r_a       <= {i_a[WIDTH-1] ^ i_signed_mode, i_a[WIDTH-2:0]};
          r_b       <= {i_b[WIDTH-1] ^ i_signed_mode, i_b[WIDTH-2:0]};
          r_ptr     <= PW'(NDIG - 1);
          r_cycles  <= '0;
          r_diff    <= 1'b0;
          r_diff_gt <= 1'b0;
        end
      end else begin
        r_cycles <= r_cycles + CW'(1);
        if (!w_last) begin
          r_ptr <= r_ptr - PW'(1);
        end
        if (!r_diff && !w_eq) begin
          r_diff    <= 1'b1;
          r_diff_gt <= w_gt;
        end
        if (w_finish) begin
          r_done <= 1'b1;
          r_gt   <= (w_res == RES_GT);
          r_eq   <= (w_res == RES_EQ);
          r_lt   <= (w_res == RES_LT);
        end
      end
    end
  end

  assign o_busy      = (r_state == CMP);
  assign o_done      = r_done;
  assign o_a_greater = r_gt;
  assign o_a_equal   = r_eq;
  assign o_a_less    = r_lt;
  assign o_cycles    = r_cycles;

endmodule

// File: doc/serial_mag_comparator.md
# serial_mag_comparator

Parametrised, sequential magnitude comparator. It compares two WIDTH-bit operands MSB-first, DIGIT bits per clock, and supports unsigned or two's-complement operands. By default it exits early on the first differing digit. It is the multi-cycle, handshaked successor to the team's combinational 2-bit comparator, for datapaths where a wide single-cycle compare is too slow or too large.

## Interface
- WIDTH, 8, operand width in bits; must be a multiple of DIGIT, ≥ 2.
- DIGIT, 2, bits examined per cycle; 1 ≤ DIGIT ≤ WIDTH.
- EARLY_EXIT, 1, 1 = finish on the first differing digit; 0 = always scan all NDIG = WIDTH/DIGIT digits.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous, active-low reset.
- start  in  1  request; sampled only in IDLE.
- signed_mode  in  1  1 = operands are two's-complement; latched at start.
- A  in  WIDTH  operand A; latched at start.
- B  in  WIDTH  operand B; latched at start.
- busy  out  1  high while in CMP.
- done  out  1  one-cycle pulse when a result is written.
- A_greater  out  1  registered result flag.
- A_equal  out  1  registered result flag.
- A_less  out  1  registered result flag.
- cycles  out  $clog2(NDIG+1)  number of digits examined by the last compare.

## Operation
- States: IDLE and CMP.
- IDLE with start=1: latch A, B and signed_mode into shadow registers, set the digit pointer to the MSB digit, clear cycles, go to CMP, busy=1.
- Signed mode: invert the MSB of both latched operands (offset binary). An unsigned digit compare then gives the signed order.
- Each CMP cycle:
  - Compare the current DIGIT-bit slice of A and B, increment cycles, move the pointer down one digit.
  - First differing digit: record GT or LT. With EARLY_EXIT=1, write the flags, pulse done and return to IDLE.
  - EARLY_EXIT=0: the first difference is held and later digits are ignored. Flags are written after the last digit.
  - Last digit with no difference recorded: result is EQ.
- Flags are one-hot after the first done. They hold their value until the next done; they are not cleared at start.
- start while busy is ignored, and no request is queued. Changes to A, B or signed_mode after latch have no effect.
- Reset, asynchronous and at any time, including mid-compare: state=IDLE, busy=0, done=0, all three flags 0, cycles=0, pointer and shadow registers 0.

## Timing
- Edge E0 samples start=1. busy is high from after E0.
- Digit k (k=0 is the MSB digit) is compared on edge E(k+1).
- On the resolving edge, the flags, cycles and done update together, and busy falls.
- Latency from the start edge to done:
  - 1..NDIG cycles with EARLY_EXIT=1.
  - Exactly NDIG cycles with EARLY_EXIT=0.
- done is high for exactly one cycle.
- A start sampled on the same edge that done is asserted is ignored, because the state is still CMP. The earliest new start is sampled on the following edge.
- Back-to-back throughput: one compare per (latency + 1) cycles.

## Structure
- Shared package comp_pkg holds:
  - the state enum (IDLE, CMP);
  - the result encoding localparams RES_GT, RES_EQ, RES_LT;
  - the helper function for NDIG and the cycles width.
- Sub-module digit_cmp: purely combinational, parametrised by DIGIT, with outputs gt, eq, lt. This is the generalised N-bit form of the existing 2-bit comparator, instantiated once on the selected slice.
- Top level holds the FSM, pointer, shadow registers and result registers. Target size is 150–250 lines.

## Test plan
All scenarios use WIDTH=8, DIGIT=2 unless stated.
- Unsigned A=0x00, B=0x00 → done after 4 cycles, A_equal=1, cycles=4.
- Unsigned A=0xC0, B=0x40, EARLY_EXIT=1 → A_greater=1, cycles=1, done one cycle after the start edge.
- Same operands with EARLY_EXIT=0 → A_greater=1, cycles=4.
- Unsigned A=0x12, B=0x13 → A_less=1, cycles=4.
- signed_mode=1, A=0x80 (−128), B=0x7F → A_less=1, cycles=1.
- Same operands with signed_mode=0 → A_greater=1.
- Start A=0x01, B=0x02, then start=1 again and the operands changed to 0xFF/0x00 while busy → the second request is ignored, A_less=1, one done pulse only.
- rst_n low for 1 ns mid-compare → busy, done, flags and cycles read 0 immediately. A following start of A=0x55, B=0x55 returns A_equal=1, cycles=4.
